// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM state type and sizing constants for the data-memory responder
package dmem_pkg;
   localparam int DEF_ADDR_WIDTH = 6;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int LAT_CNT_W      = 4;
   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: synchronous-write, registered-read word array (read returns pre-write contents)
module dmem_array
   import dmem_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);
   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
   end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: wait-state data memory for the M stage with pipeline stall output
// DMEM_POSTED_WRITE_EN: stores write on acceptance and respond the next cycle without stalling
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int LATENCY    = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  req_ready,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  stall_m
);
   localparam logic [LAT_CNT_W-1:0] CNT_INIT = LAT_CNT_W'(LATENCY - 1);
   state_t state, next_state;
   logic [LAT_CNT_W-1:0] cnt;
   logic lat_we, accept, posted, arr_we;
   logic [ADDR_WIDTH-1:0] lat_addr, arr_addr;
   logic [DATA_WIDTH-1:0] lat_wdata, arr_wdata, arr_rdata, hold_rdata;
   assign accept = state == IDLE && req_valid;
`ifdef DMEM_POSTED_WRITE_EN
   assign posted = accept && req_we;
   assign arr_we = reset && posted;
`else
   assign posted = 1'b0;
   assign arr_we = reset && state == RESP && lat_we;
`endif
   // the array reads the latched address during WAIT so its registered output is ready in RESP
   assign arr_addr   = state == IDLE ? req_addr : lat_addr;
   assign arr_wdata  = state == IDLE ? req_wdata : lat_wdata;
   assign resp_rdata = (state == RESP && !lat_we) ? arr_rdata : hold_rdata;
   dmem_array #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_array (
      .clk(clk), .we(arr_we), .addr(arr_addr), .wdata(arr_wdata), .rdata(arr_rdata)
   );
   always_comb begin
      next_state = state;
      req_ready  = 1'b0;
      stall_m    = 1'b0;
      resp_valid = 1'b0;
      case (state)
         IDLE: begin
            req_ready  = 1'b1;
            next_state = !accept ? IDLE : posted ? RESP : WAIT;
         end
         WAIT: begin
            stall_m    = 1'b1;
            next_state = cnt == '0 ? RESP : WAIT;
         end
         RESP: begin
            resp_valid = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         cnt        <= '0;
         hold_rdata <= '0;
      end else begin
         state <= next_state;
         if (accept) begin
            cnt       <= CNT_INIT;
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
         end else if (state == WAIT && cnt != '0) cnt <= cnt - LAT_CNT_W'(1);
         if (state == RESP && !lat_we) hold_rdata <= arr_rdata;
      end
   end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: table-driven scoreboard bench for LATENCY=2 and LATENCY=1 responders
module tb_dmem_responder;
   typedef struct {
      bit          sel;
      bit          we;
      logic [5:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;
   typedef struct {
      int          due;
      bit          we;
      logic [31:0] data;
      int          stall;
   } exp_t;

   logic clk = 1'b0, reset = 1'b0, sel = 1'b0;
   logic req_valid = 1'b0, req_we = 1'b0;
   logic [5:0] req_addr = '0;
   logic [31:0] req_wdata = '0, exp_in = '0;
   logic rdy_a, rv_a, st_a, rdy_b, rv_b, st_b, rdy, rv, st;
   logic [31:0] rd_a, rd_b, rd;
   logic val_a, val_b;

   exp_t sb[$];
   vec_t vecs[13];
   logic [31:0] last_rd[2];
   int tests = 0, fails = 0, ncyc = 0, stall_cnt = 0, acc_cnt = 0, prev_acc = 0;
   bit stream = 0, have_prev = 0;

   assign val_a = req_valid && !sel;
   assign val_b = req_valid && sel;
   assign rdy = sel ? rdy_b : rdy_a;
   assign rv  = sel ? rv_b : rv_a;
   assign st  = sel ? st_b : st_a;
   assign rd  = sel ? rd_b : rd_a;

   dmem_responder #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .LATENCY(2)) dut_a (
      .clk(clk), .reset(reset), .req_valid(val_a), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_ready(rdy_a), .resp_valid(rv_a), .resp_rdata(rd_a), .stall_m(st_a)
   );
   dmem_responder #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .LATENCY(1)) dut_b (
      .clk(clk), .reset(reset), .req_valid(val_b), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_ready(rdy_b), .resp_valid(rv_b), .resp_rdata(rd_b), .stall_m(st_b)
   );

   always #5 clk = ~clk;

   function automatic void check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, ncyc);
      end
   endfunction

   // negedge monitor: acceptances push expectations, responses pop and compare
   always @(negedge clk) begin
      exp_t e;
      int lat;
      ncyc++;
      if (!reset) begin
         sb.delete();
         stall_cnt  = 0;
         last_rd[0] = '0;
         last_rd[1] = '0;
      end else begin
         if (rv) begin
            if (sb.size() == 0) check(0, "spurious_resp", 32'(ncyc), 32'(0));
            else begin
               e = sb.pop_front();
               check(ncyc == e.due, "resp_time", 32'(ncyc), 32'(e.due));
               check(stall_cnt == e.stall, "stall_len", 32'(stall_cnt), 32'(e.stall));
               if (!e.we) last_rd[sel] = e.data;
               check(rd == last_rd[sel], e.we ? "store_rdata_kept" : "load_rdata", rd, last_rd[sel]);
            end
            stall_cnt = 0;
         end else check(rd == last_rd[sel], "rdata_hold", rd, last_rd[sel]);
         if (st) stall_cnt++;
         if (sb.size() > 0 && ncyc > sb[0].due) begin
            check(0, "resp_timeout", 32'(ncyc), 32'(sb[0].due));
            void'(sb.pop_front());
         end
         if (req_valid && rdy) begin
            lat     = sel ? 1 : 2;
            e.due   = ncyc + lat + 1;
            e.stall = lat;
`ifdef DMEM_POSTED_WRITE_EN
            if (req_we) begin
               e.due   = ncyc + 1;
               e.stall = 0;
            end
`endif
            e.we   = req_we;
            e.data = exp_in;
            sb.push_back(e);
            acc_cnt++;
            if (stream && have_prev) check(ncyc - prev_acc == lat + 2, "accept_spacing", 32'(ncyc - prev_acc), 32'(lat + 2));
            prev_acc  = ncyc;
            have_prev = 1;
         end
      end
   end

   task automatic issue(input bit we, input logic [5:0] a, input logic [31:0] d, input logic [31:0] e, input bit keep);
      bit done = 0;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      exp_in    = e;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (rdy) done = 1;
         @(posedge clk);
         #1;
      end
      if (!done) check(0, "accept_timeout", 32'(a), 32'(1));
      if (!keep) req_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && sb.size() > 0; i++) @(posedge clk);
      #1;
      if (sb.size() > 0) check(0, "drain_timeout", 32'(sb.size()), 32'(0));
   endtask

   initial begin
      int a0;
      logic [31:0] exp9;
      vecs[0]  = '{0, 1, 6'd5,  32'hDEADBEEF, 32'h0};
      vecs[1]  = '{0, 0, 6'd5,  32'h0,        32'hDEADBEEF};
      vecs[2]  = '{0, 1, 6'd1,  32'h11111111, 32'h0};
      vecs[3]  = '{0, 1, 6'd2,  32'h22222222, 32'h0};
      vecs[4]  = '{0, 1, 6'd9,  32'hCAFEF00D, 32'h0};
      vecs[5]  = '{0, 0, 6'd9,  32'h0,        32'hCAFEF00D};
      vecs[6]  = '{1, 1, 6'd63, 32'h3F3F3F3F, 32'h0};
      vecs[7]  = '{1, 1, 6'd0,  32'h00C0FFEE, 32'h0};
      vecs[8]  = '{1, 0, 6'd63, 32'h0,        32'h3F3F3F3F};
      vecs[9]  = '{1, 0, 6'd0,  32'h0,        32'h00C0FFEE};
      vecs[10] = '{0, 1, 6'd3,  32'hA5A5A5A5, 32'h0};
      vecs[11] = '{0, 0, 6'd3,  32'h0,        32'hA5A5A5A5};
      vecs[12] = '{0, 0, 6'd1,  32'h0,        32'h11111111};
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check(rdy_a == 1'b1, "rst_ready", 32'(rdy_a), 32'(1));
      check(rv_a == 1'b0, "rst_resp_valid", 32'(rv_a), 32'(0));
      check(st_a == 1'b0, "rst_stall", 32'(st_a), 32'(0));
      check(rd_a == 32'h0, "rst_rdata", rd_a, 32'h0);
      check(rdy_b == 1'b1, "rst_ready_lat1", 32'(rdy_b), 32'(1));
      @(posedge clk);
      #1;
      foreach (vecs[i]) begin
         sel = vecs[i].sel;
         issue(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp, 0);
         drain();
      end
      sel = 1'b0;
      stream = 1;
      have_prev = 0;
      a0 = acc_cnt;
      issue(0, 6'd1, 32'h0, 32'h11111111, 1);
      issue(0, 6'd2, 32'h0, 32'h22222222, 1);
      issue(0, 6'd1, 32'h0, 32'h11111111, 1);
      issue(0, 6'd2, 32'h0, 32'h22222222, 0);
      drain();
      stream = 0;
      check(acc_cnt - a0 == 4, "stream_accepts", 32'(acc_cnt - a0), 32'(4));
      issue(1, 6'd9, 32'h12345678, 32'h0, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check(rdy_a == 1'b1, "abort_ready", 32'(rdy_a), 32'(1));
      check(st_a == 1'b0, "abort_stall", 32'(st_a), 32'(0));
      check(rd_a == 32'h0, "abort_rdata", rd_a, 32'h0);
      repeat (6) @(posedge clk);
      #1;
`ifdef DMEM_POSTED_WRITE_EN
      exp9 = 32'h12345678;
`else
      exp9 = 32'hCAFEF00D;
`endif
      issue(0, 6'd9, 32'h0, exp9, 0);
      drain();
      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
